disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the alarm clock's common-anode 7-segment display. Holds a frame-coherent shadow copy of NUM_DIGITS 5-bit digit codes and drives them one at a time onto the shared segment decoder (`digit_holder` input), with a blanking gap between digits to suppress ghosting. It also provides per-digit blink for set/alarm-edit modes and a request/ack handshake so digit updates land only on frame boundaries.

---
 rtl/disp_pkg.sv | 13 +
 rtl/disp_blink_gen.sv | 28 ++
 rtl/disp_scan_ctrl.sv | 76 +++++++
 tb/tb_disp_scan_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared digit-code definitions for the display scan controller and segment decoder
package disp_pkg;
  localparam int DIGIT_W = 5;
  localparam logic [DIGIT_W-1:0] CODE_BLANK = 5'd16;
  localparam logic [DIGIT_W-1:0] CODE_DASH = 5'd17;
  typedef enum logic {ST_DEAD, ST_DRIVE} scan_state_t;
  function automatic logic code_valid(input logic [DIGIT_W-1:0] c);
    return c <= 5'd9 || c == CODE_BLANK || c == CODE_DASH;
  endfunction
  function automatic logic [DIGIT_W-1:0] code_clean(input logic [DIGIT_W-1:0] c);
    return code_valid(c) ? c : CODE_BLANK;
  endfunction
endpackage

// File: rtl/disp_blink_gen.sv
// disp_blink_gen: counts frames and toggles the blink phase every BLINK_FRAMES frames
module disp_blink_gen #(
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic blink_phase_nxt
);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic phase_q, phase_d, wrap;
  always_comb begin
    wrap = frame_start && fcnt_q == FW'(BLINK_FRAMES - 1);
    fcnt_d = !frame_start ? fcnt_q : wrap ? '0 : fcnt_q + 1'b1;
    phase_d = phase_q ^ wrap;
  end
  always_ff @(posedge clk)
    if (rst) begin
      fcnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      phase_q <= phase_d;
    end
  // The scan controller registers digit_holder on the same edge the phase flips
  assign blink_phase_nxt = phase_d;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 7-segment scan with frame-coherent shadow, blanking gaps and blink
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 100000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          upd_req,
  output logic                          upd_ack,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          enable,
  output logic [DIGIT_W-1:0]            digit_holder,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_start
);
  localparam int CW = $clog2((DRIVE_CYCLES > DEAD_CYCLES ? DRIVE_CYCLES : DEAD_CYCLES) + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow_q, shadow_d;
  logic [DIGIT_W-1:0] digit_holder_q, digit_holder_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic upd_ack_q, upd_ack_d, frame_start_q, frame_start_d;
  logic last, load, blank, phase_nxt;
  disp_blink_gen #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start_d),
    .blink_phase_nxt(phase_nxt)
  );
  always_comb begin
    last = cnt_q == (state_q == ST_DRIVE ? CW'(DRIVE_CYCLES - 1) : CW'(DEAD_CYCLES - 1));
    state_d = !last ? state_q : state_q == ST_DEAD ? ST_DRIVE : ST_DEAD;
    cnt_d = last ? '0 : cnt_q + 1'b1;
    idx_d = !(last && state_q == ST_DRIVE) ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
    frame_start_d = last && state_q == ST_DEAD && idx_q == '0;
    load = frame_start_d && upd_req;
    upd_ack_d = load;
    for (int i = 0; i < NUM_DIGITS; i++)
      shadow_d[i] = load ? code_clean(digits_in[DIGIT_W*i +: DIGIT_W]) : shadow_q[i];
    // Outputs follow next-state values so they stay aligned with the FSM edge
    blank = state_d == ST_DEAD || (phase_nxt && blink_mask[idx_d]);
    digit_holder_d = blank ? CODE_BLANK : shadow_d[idx_d];
    an_d = (state_d == ST_DRIVE && enable) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_DEAD;
      cnt_q <= '0;
      idx_q <= '0;
      shadow_q <= {NUM_DIGITS{CODE_BLANK}};
      digit_holder_q <= CODE_BLANK;
      an_q <= '1;
      upd_ack_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      digit_holder_q <= digit_holder_d;
      an_q <= an_d;
      upd_ack_q <= upd_ack_d;
      frame_start_q <= frame_start_d;
    end
  assign digit_holder = digit_holder_q;
  assign an = an_q;
  assign upd_ack = upd_ack_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed frame-by-frame checks of scan timing, updates, sanitising, blink, enable and reset
module tb_disp_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, upd_req = 1'b0, enable = 1'b1;
  logic [19:0] digits_in = '0;
  logic [3:0] blink_mask = '0;
  logic upd_ack, frame_start;
  logic [4:0] digit_holder;
  logic [3:0] an;
  int tests = 0, fails = 0;

  disp_scan_ctrl #(.NUM_DIGITS(4), .DRIVE_CYCLES(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .blink_mask  (blink_mask),
    .enable      (enable),
    .digit_holder(digit_holder),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] e_an, input logic [4:0] e_dh,
                       input logic e_ack, input logic e_fs);
    tests++;
    assert (an === e_an && digit_holder === e_dh && upd_ack === e_ack && frame_start === e_fs)
    else begin
      fails++;
      $error("FAIL %s: got an=%b dh=%0d ack=%b fs=%b, want an=%b dh=%0d ack=%b fs=%b",
             tag, an, digit_holder, upd_ack, frame_start, e_an, e_dh, e_ack, e_fs);
    end
  endtask

  // Called at the sample point just after a frame boundary edge; checks all 20 cycles.
  // After the check at cycle set_k, upd_req and enable take req_v and en_v.
  task automatic run_frame(input string tag, input logic [4:0] d0, d1, d2, d3, input logic en,
                           input logic ack, input int set_k, input logic req_v, input logic en_v);
    logic [4:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 20; k++) begin
      int j = k / 5;
      if (k % 5 < 4)
        check($sformatf("%s[%0d]", tag, k), en ? ~(4'b0001 << j) : 4'b1111, d[j], ack && k == 0, k == 0);
      else
        check($sformatf("%s[%0d]", tag, k), 4'b1111, 5'd16, 1'b0, 1'b0);
      if (k == set_k) begin
        upd_req = req_v;
        enable = en_v;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset", 4'b1111, 5'd16, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    digits_in = {5'd9, 5'd17, 5'd3, 5'd0};
    run_frame("idle", 16, 16, 16, 16, 1, 0, 10, 1, 1);
    run_frame("upd", 0, 3, 17, 9, 1, 1, 0, 0, 1);
    digits_in = {5'd31, 5'd12, 5'd5, 5'd10};
    run_frame("hold", 0, 3, 17, 9, 1, 0, 5, 1, 1);
    run_frame("inval", 16, 5, 16, 16, 1, 1, 0, 0, 1);
    digits_in = {5'd1, 5'd2, 5'd3, 5'd4};
    run_frame("inval2", 16, 5, 16, 16, 1, 0, 3, 1, 1);
    blink_mask = 4'b0010;
    run_frame("blink6", 4, 16, 2, 1, 1, 1, 0, 0, 1);
    run_frame("blink7", 4, 16, 2, 1, 1, 0, -1, 0, 1);
    run_frame("blink8", 4, 3, 2, 1, 1, 0, -1, 0, 1);
    run_frame("blink9", 4, 3, 2, 1, 1, 0, -1, 0, 1);
    digits_in = {5'd5, 5'd6, 5'd7, 5'd8};
    run_frame("blink10", 4, 16, 2, 1, 1, 0, 19, 1, 0);
    blink_mask = 4'b0000;
    run_frame("en_off", 8, 7, 6, 5, 0, 1, 0, 0, 0);
    enable = 1'b1;
    upd_req = 1'b1;
    repeat (11) @(negedge clk);
    check("mid_drive", 4'b1011, 5'd6, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", 4'b1111, 5'd16, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    run_frame("post_rst", 8, 7, 6, 5, 1, 1, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
